// File: rtl/rast_pkg.sv
// rast_pkg: shared types and constants for the colour buffer writer.
package rast_pkg;

  // Writer sequencing states; READ is only reachable when blending is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } cbw_state_t;

  // RGB565 channel boundaries within a colour word.
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  localparam int CBW_ADDR_W   = 32;
  localparam int CBW_COLOUR_W = 16;

  // One queued fragment: its final word address and its source colour.
  typedef struct packed {
    logic [CBW_ADDR_W-1:0]   addr;
    logic [CBW_COLOUR_W-1:0] colour;
  } cbw_fifo_entry_t;

endpackage

// File: rtl/frag_fifo.sv
// frag_fifo: small synchronous FIFO with first-word fall-through head output.
// A push while full is dropped even if a pop happens in the same cycle.
module frag_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign data_o  = mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= data_i;
    end
  end

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/colour_buffer_writer.sv
// colour_buffer_writer: queues depth-passed fragments and writes their colour
// into a linear colour buffer; also clears the whole buffer to a given colour.
// Build option CBW_BLEND_EN: read the destination pixel first and write the
// per-channel average of source and destination.
module colour_buffer_writer
  import rast_pkg::*;
#(
  parameter int COLOUR_SIZE  = 16,
  parameter int X_RES        = 4,
  parameter int Y_RES        = 4,
  parameter int X_PIXEL_SIZE = $clog2(X_RES),
  parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
  parameter int ADDR_SIZE    = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frag_valid_i,
  output logic                    frag_ready_o,
  input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
  input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
  input  logic [COLOUR_SIZE-1:0]  frag_colour_i,
  input  logic                    depth_pass_i,
  input  logic [ADDR_SIZE-1:0]    buffer_base_address_i,
  input  logic                    clear_i,
  input  logic [COLOUR_SIZE-1:0]  clear_colour_i,
  output logic                    buf_r_w,
  output logic [ADDR_SIZE-1:0]    buf_addr,
  output logic [COLOUR_SIZE-1:0]  buf_data_w,
  input  logic [COLOUR_SIZE-1:0]  buf_data_r,
  input  logic                    data_r_valid,
  output logic                    data_r_ready,
  output logic                    data_w_valid,
  input  logic                    data_w_ready,
  output logic                    busy_o,
  output logic                    clear_done_o,
  output logic [15:0]             written_count_o
);

  localparam int PIXELS = X_RES * Y_RES;

  cbw_state_t               state_reg;
  logic                     clear_pending_reg;
  logic                     buf_r_w_reg;
  logic [ADDR_SIZE-1:0]     buf_addr_reg;
  logic [COLOUR_SIZE-1:0]   buf_data_w_reg;
  logic                     data_w_valid_reg;
  logic                     clear_done_reg;
  logic [15:0]              written_count_reg;

  cbw_fifo_entry_t          push_entry;
  cbw_fifo_entry_t          head_entry;
  logic [$bits(cbw_fifo_entry_t)-1:0] head_bits;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     w_handshake;
  logic [ADDR_SIZE-1:0]     frag_addr;
  logic [ADDR_SIZE-1:0]     clear_last_addr;

  // Fragments are refused while a clear is waiting or running so the clear
  // sees a stable buffer.
  assign frag_ready_o = !fifo_full && !clear_pending_reg && (state_reg != CLEAR);
  assign push         = frag_valid_i && frag_ready_o && depth_pass_i;
  assign pop          = (state_reg == IDLE) && !fifo_empty;
  assign w_handshake  = data_w_valid_reg && data_w_ready;

  assign frag_addr = buffer_base_address_i
                   + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES)
                   + ADDR_SIZE'(frag_x_i);
  assign clear_last_addr = buffer_base_address_i + ADDR_SIZE'(PIXELS - 1);

  assign push_entry = '{addr: frag_addr, colour: frag_colour_i};
  assign head_entry = cbw_fifo_entry_t'(head_bits);

  frag_fifo #(
    .WIDTH ($bits(cbw_fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_frag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign buf_r_w         = buf_r_w_reg;
  assign buf_addr        = buf_addr_reg;
  assign buf_data_w      = buf_data_w_reg;
  assign data_w_valid    = data_w_valid_reg;
  assign clear_done_o    = clear_done_reg;
  assign written_count_o = written_count_reg;
  assign busy_o          = !fifo_empty || (state_reg != IDLE) || clear_pending_reg;

`ifdef CBW_BLEND_EN
  logic                   data_r_ready_reg;
  logic [COLOUR_SIZE-1:0] src_colour_reg;
  logic [COLOUR_SIZE-1:0] blend_colour;

  localparam int CH_MSB [3] = '{RGB_R_MSB, RGB_G_MSB, RGB_B_MSB};
  localparam int CH_LSB [3] = '{RGB_R_LSB, RGB_G_LSB, RGB_B_LSB};

  assign data_r_ready = data_r_ready_reg;

  // Per-channel average; each channel keeps its own carry so nothing spills over.
  for (genvar gi = 0; gi < 3; gi++) begin : g_blend
    localparam int W = CH_MSB[gi] - CH_LSB[gi] + 1;
    logic [W:0] ch_sum;
    assign ch_sum = (W+1)'(src_colour_reg[CH_MSB[gi]:CH_LSB[gi]])
                  + (W+1)'(buf_data_r[CH_MSB[gi]:CH_LSB[gi]]);
    assign blend_colour[CH_MSB[gi]:CH_LSB[gi]] = ch_sum[W:1];
  end
`else
  // Without blending the read channel is never used.
  assign data_r_ready = 1'b0;
  logic unused_read;
  assign unused_read = &{1'b0, buf_data_r, data_r_valid};
`endif

  // Sequencer: drains the queue, runs the clear, and owns every memory-port output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      clear_pending_reg <= 1'b0;
      buf_r_w_reg       <= 1'b1;
      buf_addr_reg      <= '0;
      buf_data_w_reg    <= '0;
      data_w_valid_reg  <= 1'b0;
      clear_done_reg    <= 1'b0;
      written_count_reg <= '0;
`ifdef CBW_BLEND_EN
      data_r_ready_reg  <= 1'b0;
      src_colour_reg    <= '0;
`endif
    end else begin
      clear_done_reg <= 1'b0;
      if (clear_i && !clear_pending_reg && (state_reg != CLEAR)) begin
        clear_pending_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (clear_pending_reg && fifo_empty) begin
            state_reg        <= CLEAR;
            buf_addr_reg     <= buffer_base_address_i;
            buf_data_w_reg   <= clear_colour_i;
            buf_r_w_reg      <= 1'b0;
            data_w_valid_reg <= 1'b1;
          end else if (!fifo_empty) begin
`ifdef CBW_BLEND_EN
            state_reg        <= READ;
            buf_addr_reg     <= head_entry.addr;
            src_colour_reg   <= head_entry.colour;
            buf_r_w_reg      <= 1'b1;
            data_r_ready_reg <= 1'b1;
`else
            state_reg        <= WRITE;
            buf_addr_reg     <= head_entry.addr;
            buf_data_w_reg   <= head_entry.colour;
            buf_r_w_reg      <= 1'b0;
            data_w_valid_reg <= 1'b1;
`endif
          end
        end
`ifdef CBW_BLEND_EN
        READ: begin
          if (data_r_valid && data_r_ready_reg) begin
            data_r_ready_reg <= 1'b0;
            buf_data_w_reg   <= blend_colour;
            buf_r_w_reg      <= 1'b0;
            data_w_valid_reg <= 1'b1;
            state_reg        <= WRITE;
          end
        end
`endif
        WRITE: begin
          if (w_handshake) begin
            data_w_valid_reg  <= 1'b0;
            written_count_reg <= written_count_reg + 16'd1;
            state_reg         <= IDLE;
          end
        end
        CLEAR: begin
          if (w_handshake) begin
            if (buf_addr_reg == clear_last_addr) begin
              data_w_valid_reg <= 1'b0;
              clear_done_reg   <= 1'b1;
              state_reg        <= DONE;
            end else begin
              buf_addr_reg <= buf_addr_reg + ADDR_SIZE'(1);
            end
          end
        end
        DONE: begin
          clear_pending_reg <= 1'b0;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_buffer_writer.sv
// tb_colour_buffer_writer: directed vectors with hand-computed expectations.
module tb_colour_buffer_writer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        frag_valid_i;
  logic        frag_ready_o;
  logic [1:0]  frag_x_i;
  logic [1:0]  frag_y_i;
  logic [15:0] frag_colour_i;
  logic        depth_pass_i;
  logic [31:0] buffer_base_address_i;
  logic        clear_i;
  logic [15:0] clear_colour_i;
  logic        buf_r_w;
  logic [31:0] buf_addr;
  logic [15:0] buf_data_w;
  logic [15:0] buf_data_r;
  logic        data_r_valid;
  logic        data_r_ready;
  logic        data_w_valid;
  logic        data_w_ready;
  logic        busy_o;
  logic        clear_done_o;
  logic [15:0] written_count_o;

  always #5 clk_i = ~clk_i;

  colour_buffer_writer dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .frag_valid_i          (frag_valid_i),
    .frag_ready_o          (frag_ready_o),
    .frag_x_i              (frag_x_i),
    .frag_y_i              (frag_y_i),
    .frag_colour_i         (frag_colour_i),
    .depth_pass_i          (depth_pass_i),
    .buffer_base_address_i (buffer_base_address_i),
    .clear_i               (clear_i),
    .clear_colour_i        (clear_colour_i),
    .buf_r_w               (buf_r_w),
    .buf_addr              (buf_addr),
    .buf_data_w            (buf_data_w),
    .buf_data_r            (buf_data_r),
    .data_r_valid          (data_r_valid),
    .data_r_ready          (data_r_ready),
    .data_w_valid          (data_w_valid),
    .data_w_ready          (data_w_ready),
    .busy_o                (busy_o),
    .clear_done_o          (clear_done_o),
    .written_count_o       (written_count_o)
  );

  int          vec_count = 0;
  int          miscompare_count = 0;
  logic [31:0] log_addr [$];
  logic [15:0] log_data [$];
  int          done_pulses = 0;
  int          stall_errors = 0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_addr;
  logic [15:0] prev_data;
  logic        prev_rw;

  // Fragment tables for the stall test (4x4 buffer, base 0x200).
  int          t3_x [6] = '{3, 0, 2, 1, 3, 0};
  int          t3_y [6] = '{3, 1, 0, 3, 0, 2};
  logic [15:0] t3_col [6] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 16'hF006};
  logic [31:0] t3_addr [6] = '{32'h20F, 32'h204, 32'h202, 32'h20D, 32'h203, 32'h208};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (log_addr.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, log_addr.size(), n);
  endtask

  // Write-port monitor: logs each handshake that completes at the next edge
  // and flags any request whose payload moves while stalled.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && data_w_valid &&
          (buf_addr !== prev_addr || buf_data_w !== prev_data || buf_r_w !== prev_rw))
        stall_errors++;
      if (data_w_valid && data_w_ready) begin
        log_addr.push_back(buf_addr);
        log_data.push_back(buf_data_w);
        $display("write #%0d addr=%h data=%h", log_addr.size(), buf_addr, buf_data_w);
      end
      if (clear_done_o) done_pulses++;
      stalled_prev = data_w_valid && !data_w_ready;
      prev_addr    = buf_addr;
      prev_data    = buf_data_w;
      prev_rw      = buf_r_w;
    end
  end

  initial begin
    int acc;
    int n;
    logic was;
    rst_ni = 1'b0;
    frag_valid_i = 1'b0;
    frag_x_i = 2'd0;
    frag_y_i = 2'd0;
    frag_colour_i = 16'h0;
    depth_pass_i = 1'b0;
    buffer_base_address_i = 32'h100;
    clear_i = 1'b0;
    clear_colour_i = 16'h0;
    buf_data_r = 16'h0;
    data_r_valid = 1'b0;
    data_w_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(data_w_valid), 0);
    check("rst_rw", 32'(buf_r_w), 1);
    check("rst_addr", buf_addr, 0);
    check("rst_data", 32'(buf_data_w), 0);
    check("rst_count", 32'(written_count_o), 0);
    check("rst_rready", 32'(data_r_ready), 0);
    check("rst_done", 32'(clear_done_o), 0);
    check("rst_fready", 32'(frag_ready_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    rst_ni = 1'b1;
    step();

`ifdef CBW_BLEND_EN
    // Blend: src FFFF over dst 0000 at (1,2) -> read 0x109, write 7BEF.
    data_w_ready = 1'b1;
    data_r_valid = 1'b1;
    buf_data_r = 16'h0000;
    frag_valid_i = 1'b1; frag_x_i = 2'd1; frag_y_i = 2'd2;
    frag_colour_i = 16'hFFFF; depth_pass_i = 1'b1;
    step();
    frag_valid_i = 1'b0;
    check("bl_rready_n1", 32'(data_r_ready), 0);
    step();
    check("bl_rready_n2", 32'(data_r_ready), 1);
    check("bl_raddr", buf_addr, 32'h109);
    check("bl_rw_read", 32'(buf_r_w), 1);
    step();
    check("bl_wvalid", 32'(data_w_valid), 1);
    check("bl_wdata", 32'(buf_data_w), 32'h7BEF);
    check("bl_rw_write", 32'(buf_r_w), 0);
    step();
    check("bl_count", 32'(written_count_o), 1);
    // src 8410 (16,32,16) over dst 0841 (1,2,1) -> (8,17,8) = 4228 at 0x103.
    buf_data_r = 16'h0841;
    frag_valid_i = 1'b1; frag_x_i = 2'd3; frag_y_i = 2'd0;
    frag_colour_i = 16'h8410;
    step();
    frag_valid_i = 1'b0;
    wait_writes("bl_wait2", 2, 20);
    check("bl_addr2", log_addr[1], 32'h103);
    check("bl_data2", 32'(log_data[1]), 32'h4228);
`else
    // Single fragment (1,2) at base 0x100 -> 0x109, valid at N+2.
    data_w_ready = 1'b1;
    frag_valid_i = 1'b1; frag_x_i = 2'd1; frag_y_i = 2'd2;
    frag_colour_i = 16'hF800; depth_pass_i = 1'b1;
    check("t1_fready", 32'(frag_ready_o), 1);
    step();
    frag_valid_i = 1'b0;
    check("t1_valid_n1", 32'(data_w_valid), 0);
    step();
    check("t1_valid_n2", 32'(data_w_valid), 1);
    check("t1_addr", buf_addr, 32'h109);
    check("t1_data", 32'(buf_data_w), 32'hF800);
    check("t1_rw", 32'(buf_r_w), 0);
    step();
    check("t1_valid_drop", 32'(data_w_valid), 0);
    check("t1_count", 32'(written_count_o), 1);
    check("t1_logn", log_addr.size(), 1);

    // Depth-failed fragment is consumed without a memory write.
    frag_valid_i = 1'b1; frag_x_i = 2'd3; frag_y_i = 2'd3;
    frag_colour_i = 16'h1234; depth_pass_i = 1'b0;
    check("t2_fready", 32'(frag_ready_o), 1);
    step();
    frag_valid_i = 1'b0;
    repeat (4) step();
    check("t2_logn", log_addr.size(), 1);
    check("t2_count", 32'(written_count_o), 1);
    check("t2_busy", 32'(busy_o), 0);

    // Six fragments into a stalled port: four queue plus one held in the
    // write register, then ready drops; after release all six go out in order.
    buffer_base_address_i = 32'h200;
    data_w_ready = 1'b0;
    depth_pass_i = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (acc < 6) begin
        frag_valid_i = 1'b1;
        frag_x_i = 2'(t3_x[acc]); frag_y_i = 2'(t3_y[acc]);
        frag_colour_i = t3_col[acc];
      end else frag_valid_i = 1'b0;
      was = frag_valid_i && frag_ready_o;
      step();
      if (was) acc++;
    end
    check("t3_accepted_stalled", acc, 5);
    check("t3_fready_low", 32'(frag_ready_o), 0);
    check("t3_stall_valid", 32'(data_w_valid), 1);
    check("t3_stall_addr", buf_addr, 32'h20F);
    check("t3_stall_logn", log_addr.size(), 1);
    data_w_ready = 1'b1;
    for (int c = 0; c < 60 && (acc < 6 || log_addr.size() < 7); c++) begin
      if (acc < 6) begin
        frag_valid_i = 1'b1;
        frag_x_i = 2'(t3_x[acc]); frag_y_i = 2'(t3_y[acc]);
        frag_colour_i = t3_col[acc];
      end else frag_valid_i = 1'b0;
      was = frag_valid_i && frag_ready_o;
      step();
      if (was) acc++;
    end
    frag_valid_i = 1'b0;
    check("t3_accepted", acc, 6);
    check("t3_logn", log_addr.size(), 7);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_addr%0d", i), log_addr[1+i], t3_addr[i]);
      check($sformatf("t3_data%0d", i), 32'(log_data[1+i]), 32'(t3_col[i]));
    end
    check("t3_count", 32'(written_count_o), 7);

    // Clear requested with two fragments outstanding: fragments first, then
    // 16 clear writes; a second clear_i during CLEAR must be ignored.
    buffer_base_address_i = 32'h100;
    data_w_ready = 1'b0;
    frag_valid_i = 1'b1; frag_x_i = 2'd0; frag_y_i = 2'd0; frag_colour_i = 16'h1111;
    step();
    frag_x_i = 2'd2; frag_y_i = 2'd3; frag_colour_i = 16'h2222;
    step();
    frag_valid_i = 1'b0;
    clear_colour_i = 16'h001F;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("t4_fready_pending", 32'(frag_ready_o), 0);
    check("t4_busy", 32'(busy_o), 1);
    data_w_ready = 1'b1;
    for (int c = 0; c < 200 && (log_addr.size() < 25 || done_pulses < 1); c++) begin
      clear_i = (log_addr.size() == 12);
      step();
    end
    clear_i = 1'b0;
    repeat (30) step();
    check("t4_logn", log_addr.size(), 25);
    check("t4_frag0_addr", log_addr[7], 32'h100);
    check("t4_frag0_data", 32'(log_data[7]), 32'h1111);
    check("t4_frag1_addr", log_addr[8], 32'h10E);
    check("t4_frag1_data", 32'(log_data[8]), 32'h2222);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t4_clr_addr%0d", k), log_addr[9+k], 32'h100 + 32'(k));
      check($sformatf("t4_clr_data%0d", k), 32'(log_data[9+k]), 32'h001F);
    end
    check("t4_done_pulses", done_pulses, 1);
    check("t4_count", 32'(written_count_o), 9);
    check("t4_busy_after", 32'(busy_o), 0);
    check("t4_fready_after", 32'(frag_ready_o), 1);

    // Reset while a write is stalled with another fragment queued.
    data_w_ready = 1'b0;
    frag_valid_i = 1'b1; frag_x_i = 2'd1; frag_y_i = 2'd1; frag_colour_i = 16'h3333;
    step();
    frag_x_i = 2'd2; frag_y_i = 2'd2; frag_colour_i = 16'h4444;
    step();
    frag_valid_i = 1'b0;
    step();
    check("t5_stalled", 32'(data_w_valid), 1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_valid", 32'(data_w_valid), 0);
    check("t5_rst_rw", 32'(buf_r_w), 1);
    check("t5_rst_addr", buf_addr, 0);
    check("t5_rst_data", 32'(buf_data_w), 0);
    check("t5_rst_count", 32'(written_count_o), 0);
    check("t5_rst_busy", 32'(busy_o), 0);
    step();
    rst_ni = 1'b1;
    step();
    data_w_ready = 1'b1;
    n = log_addr.size();
    frag_valid_i = 1'b1; frag_x_i = 2'd2; frag_y_i = 2'd1; frag_colour_i = 16'h07E0;
    step();
    frag_valid_i = 1'b0;
    wait_writes("t5_wait", n + 1, 20);
    check("t5_addr", log_addr[n], 32'h106);
    check("t5_data", 32'(log_data[n]), 32'h07E0);
    repeat (5) step();
    check("t5_no_stale", log_addr.size(), n + 1);
    check("t5_count", 32'(written_count_o), 1);
`endif

    check("stall_hold", stall_errors, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
